// File: rtl/wb_rr_arbiter_pkg.sv
// Shared bus-width defaults, arbiter state encoding and grant helper
// for the two-master Wishbone round-robin arbiter.
package wb_rr_arbiter_pkg;

  localparam int WB_ADDR_W_DEF   = 24;
  localparam int WB_DATA_W_DEF   = 16;
  localparam int WB_SEL_BITS_DEF = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  // One-hot debug grant vector for a given arbiter state.
  function automatic logic [1:0] gnt_of(input arb_state_e s);
    case (s)
      ARB_GNT0: gnt_of = 2'b01;
      ARB_GNT1: gnt_of = 2'b10;
      default:  gnt_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transfer watchdog: pulses tmo for one cycle when a strobe has gone
// unanswered for TIMEOUT cycles. TIMEOUT == 0 removes the counter entirely.
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic answered,
  input  logic clear,
  output logic tmo
);

  if (TIMEOUT == 0) begin : g_off
    assign tmo = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tmo_q, tmo_d;

    // A response in the final cycle beats the timeout: answered is tested first.
    always_comb begin
      count_d = '0;
      tmo_d   = 1'b0;
      if (!clear && active && !answered) begin
        if (count_q == LAST) begin
          tmo_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        count_q <= '0;
        tmo_q   <= 1'b0;
      end else begin
        count_q <= count_d;
        tmo_q   <= tmo_d;
      end
    end

    assign tmo = tmo_q;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant locked for a
// whole bus cycle, with a watchdog that errors unanswered strobes.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int WB_ADDR_W   = WB_ADDR_W_DEF,
  parameter int WB_DATA_W   = WB_DATA_W_DEF,
  parameter int WB_SEL_BITS = WB_SEL_BITS_DEF,
  parameter int TIMEOUT     = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,

  input  logic                   m0_wb_cyc,
  input  logic                   m0_wb_stb,
  input  logic                   m0_wb_we,
  input  logic [WB_ADDR_W-1:0]   m0_wb_adr,
  input  logic [WB_DATA_W-1:0]   m0_wb_o_dat,
  input  logic [WB_SEL_BITS-1:0] m0_wb_sel,
  output logic [WB_DATA_W-1:0]   m0_wb_i_dat,
  output logic                   m0_wb_ack,
  output logic                   m0_wb_err,

  input  logic                   m1_wb_cyc,
  input  logic                   m1_wb_stb,
  input  logic                   m1_wb_we,
  input  logic [WB_ADDR_W-1:0]   m1_wb_adr,
  input  logic [WB_DATA_W-1:0]   m1_wb_o_dat,
  input  logic [WB_SEL_BITS-1:0] m1_wb_sel,
  output logic [WB_DATA_W-1:0]   m1_wb_i_dat,
  output logic                   m1_wb_ack,
  output logic                   m1_wb_err,

  output logic                   s_wb_cyc,
  output logic                   s_wb_stb,
  output logic                   s_wb_we,
  output logic [WB_ADDR_W-1:0]   s_wb_adr,
  output logic [WB_DATA_W-1:0]   s_wb_o_dat,
  output logic [WB_SEL_BITS-1:0] s_wb_sel,
  input  logic [WB_DATA_W-1:0]   s_wb_i_dat,
  input  logic                   s_wb_ack,
  input  logic                   s_wb_err,

  output logic [1:0]             o_gnt
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic       tmo;
  logic       gnt_stb;

  // last_gnt holds the index of the master that most recently released.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_wb_cyc && m1_wb_cyc) state_d = last_gnt_q ? ARB_GNT0 : ARB_GNT1;
        else if (m0_wb_cyc)         state_d = ARB_GNT0;
        else if (m1_wb_cyc)         state_d = ARB_GNT1;
      end
      ARB_GNT0: begin
        if (!m0_wb_cyc) begin
          last_gnt_d = 1'b0;
          state_d    = m1_wb_cyc ? ARB_GNT1 : ARB_IDLE;
        end
      end
      ARB_GNT1: begin
        if (!m1_wb_cyc) begin
          last_gnt_d = 1'b1;
          state_d    = m0_wb_cyc ? ARB_GNT0 : ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    gnt_d = gnt_of(state_d);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign m0_wb_i_dat = s_wb_i_dat;
  assign m1_wb_i_dat = s_wb_i_dat;

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    s_wb_cyc   = 1'b0;
    s_wb_stb   = 1'b0;
    s_wb_we    = 1'b0;
    s_wb_adr   = '0;
    s_wb_o_dat = '0;
    s_wb_sel   = '0;
    m0_wb_ack  = 1'b0;
    m0_wb_err  = 1'b0;
    m1_wb_ack  = 1'b0;
    m1_wb_err  = 1'b0;
    gnt_stb    = 1'b0;
    case (state_q)
      ARB_GNT0: begin
        s_wb_cyc   = m0_wb_cyc;
        s_wb_stb   = m0_wb_stb & ~tmo;
        s_wb_we    = m0_wb_we;
        s_wb_adr   = m0_wb_adr;
        s_wb_o_dat = m0_wb_o_dat;
        s_wb_sel   = m0_wb_sel;
        m0_wb_ack  = s_wb_ack & ~tmo;
        m0_wb_err  = s_wb_err | tmo;
        gnt_stb    = m0_wb_stb;
      end
      ARB_GNT1: begin
        s_wb_cyc   = m1_wb_cyc;
        s_wb_stb   = m1_wb_stb & ~tmo;
        s_wb_we    = m1_wb_we;
        s_wb_adr   = m1_wb_adr;
        s_wb_o_dat = m1_wb_o_dat;
        s_wb_sel   = m1_wb_sel;
        m1_wb_ack  = s_wb_ack & ~tmo;
        m1_wb_err  = s_wb_err | tmo;
        gnt_stb    = m1_wb_stb;
      end
      default: ;
    endcase
  end

  // The watchdog watches the raw master strobe so a held stb keeps counting
  // through the tmo cycle and the next beat times out TIMEOUT cycles later.
  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .active   (s_wb_cyc & gnt_stb),
    .answered (s_wb_ack | s_wb_err),
    .clear    (state_d != state_q),
    .tmo      (tmo)
  );

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Two-master to one-slave Wishbone arbiter that shares the SoC peripheral bus (SDRAM, ROM, UART, timer, IRQC, SPI decode) between the CPU bus master (wb_decomp output) and a second master (DMA engine).
- Grant is round-robin and held for a whole bus cycle (cyc-locked).
- A per-transfer watchdog returns err to the granted master when no slave acks, e.g. an unmapped address where the decoder leaves ack low.

Parameters:
- WB_ADDR_W, 24, address width
- WB_DATA_W, 16, data width
- WB_SEL_BITS, 2, byte-select width
- TIMEOUT, 255, cycles of unanswered stb before err; 0 disables the watchdog

Ports:
- i_clk  in  1  bus clock
- i_rst  in  1  synchronous reset, active-low
- m0_wb_cyc, m0_wb_stb, m0_wb_we  in  1 each  master 0 control
- m0_wb_adr  in  WB_ADDR_W  master 0 address
- m0_wb_o_dat  in  WB_DATA_W  master 0 write data
- m0_wb_sel  in  WB_SEL_BITS  master 0 byte select
- m0_wb_i_dat  out  WB_DATA_W  master 0 read data
- m0_wb_ack, m0_wb_err  out  1 each  master 0 response
- m1_*  same set as m0_*  master 1
- s_wb_cyc, s_wb_stb, s_wb_we  out  1 each  slave control
- s_wb_adr  out  WB_ADDR_W  slave address
- s_wb_o_dat  out  WB_DATA_W  slave write data
- s_wb_sel  out  WB_SEL_BITS  slave byte select
- s_wb_i_dat  in  WB_DATA_W  slave read data
- s_wb_ack, s_wb_err  in  1 each  slave response
- o_gnt  out  2  one-hot grant (bit n = master n), debug

Behaviour:
- Reset (i_rst==0 at posedge): state IDLE, last_gnt=1 so master 0 wins the first tie, watchdog count=0, tmo=0.
  - Outputs during/after reset: s_wb_cyc=0, s_wb_stb=0, all m*_ack/err=0, o_gnt=0.
  - Reset mid-transfer: slave cyc/stb drop the cycle after the reset edge; no ack/err is delivered for the aborted transfer.
- States:
  - IDLE: no grant.
  - GNT0, GNT1: grant held for master n.
- IDLE -> GNTn at the posedge where a request is sampled.
  - Only one m*_wb_cyc high: grant that master.
  - Both high: grant the master != last_gnt.
  - Latency: cyc high at edge k gives s_wb_cyc high after edge k (1 cycle).
- In GNTn, slave outputs are combinational from master n:
  - s_wb_cyc=mn_wb_cyc
  - s_wb_stb=mn_wb_stb & ~tmo
  - adr, we, o_dat and sel passed straight through.
- Release: posedge in GNTn with mn_wb_cyc==0.
  - Set last_gnt<=n.
  - Direct handover: if the other master's cyc is high, go to its GNT state at that edge (no IDLE bubble); else IDLE.
  - Master n may not re-win until the other master has been served or is idle.
- Grant is never revoked while the granted cyc is high, including multiple stb beats inside one cyc.
- Responses:
  - Granted master: mn_wb_ack=s_wb_ack & ~tmo; mn_wb_err=s_wb_err | tmo.
  - Ungranted master: ack=err=0.
  - m0_wb_i_dat and m1_wb_i_dat both = s_wb_i_dat (broadcast); only meaningful with ack.
- Watchdog (TIMEOUT>0):
  - Count increments each cycle with s_wb_cyc & mn_wb_stb & ~s_wb_ack & ~s_wb_err.
  - Count clears on ack, on err, on stb low, or on grant change.
  - When count==TIMEOUT-1 and still unanswered: tmo<=1 for exactly one cycle and count<=0.
  - Consequence: err appears TIMEOUT cycles after stb rises.
  - Slave ack in the same cycle tmo would be set: ack wins and tmo is not set.
  - Count width: $clog2(TIMEOUT+1).
- TIMEOUT==0: tmo is constant 0.
- o_gnt is registered state: 2'b01 in GNT0, 2'b10 in GNT1, 0 in IDLE.

Decomposition:
- Shared config include: WB_ADDR_W, WB_DATA_W and WB_SEL_BITS defaults, and the state encoding localparams (ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2).
- One sub-module, wb_arb_watchdog.
  - Inputs: clk, rst, active, answered, clear.
  - Output: tmo pulse.
  - Parameter: TIMEOUT.
- The round-robin FSM and muxing stay in wb_rr_arbiter.

Test Plan:
1. Reset, then m0 only: cyc/stb, adr=24'h002000, write 16'hA5A5, slave acks 1 cycle later -> s_wb_cyc high 1 cycle after m0 cyc, s_wb_o_dat=16'hA5A5, m0_wb_ack=1 for 1 cycle, m1_wb_ack=0, o_gnt=2'b01.
2. Both masters raise cyc in the same cycle after reset -> m0 granted first; m0 drops cyc -> m1 granted at that edge with no IDLE cycle (o_gnt 01->10); m0 re-requests during m1's cycle -> m0 granted only after m1 releases.
3. m1 holds cyc through 3 stb beats, adr 24'h100000..24'h100002, slave read data 16'h1111/2222/3333, while m0 requests -> grant stays with m1 for all 3 beats; m1_wb_i_dat matches each ack; m0 waits.
4. TIMEOUT=8, m0 reads adr 24'h003000, slave never acks -> m0_wb_err=1 exactly 8 cycles after stb, s_wb_stb low in that cycle, no m0_wb_ack; the following transfer times out again after 8 more cycles.
5. TIMEOUT=8, slave ack arrives in the 8th cycle -> m0_wb_ack=1, m0_wb_err=0.
6. Assert i_rst=0 mid-transfer while granted to m1 -> s_wb_cyc=0 and o_gnt=0 from the next cycle; no ack/err to m1; after release, a tie grants m0.
